// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only data memory.
// Turns RV32I loads and stores into single-word accesses. Sub-word stores are
// done as a read-modify-write. Load data is lane-extracted and then sign- or
// zero-extended. Requests that are misaligned, out of range or use an illegal
// funct3 are answered with an error and never reach the memory.
module lsu_rmw #(
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_done,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dmem_MemRead,
    output logic        dmem_MemWrite,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_WriteData,
    input  logic [31:0] dmem_ReadData
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]  state_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    // Only the low half of the store data is ever merged. A full-word store
    // loads the merge register directly at accept.
    logic [15:0] wdata_reg;
    logic [31:0] merge_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        req_fault;
    logic        f3_legal;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;
    logic [31:0] merge_word;

    // Classify the incoming request. The funct3 must be legal, the address
    // must be aligned to the access size, and the word index must be in range.
    always_comb begin
        f3_legal = 1'b0;
        if (req_we) begin
            f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                       (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
        req_fault = !f3_legal
                 || ((req_funct3[1:0] == 2'b01) && req_addr[0])
                 || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
                 || (req_addr[31:2] >= 30'(DMEM_WORDS));
    end

    // Pick the addressed lane out of the memory word and extend it to 32 bits.
    always_comb begin
        ld_byte = dmem_ReadData[{addr_reg[1:0], 3'b000} +: 8];
        ld_half = addr_reg[1] ? dmem_ReadData[31:16] : dmem_ReadData[15:0];
        case (funct3_reg)
            3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_result = {24'd0, ld_byte};
            3'b101:  ld_result = {16'd0, ld_half};
            default: ld_result = dmem_ReadData;
        endcase
    end

    // Build the merged word one byte lane at a time. A lane takes the new
    // store data when the access covers it; otherwise it keeps the old byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_hit;
            logic [7:0] lane_src;
            assign lane_hit = (funct3_reg[1:0] == 2'b00) ? (addr_reg[1:0] == 2'(gi))
                                                         : (addr_reg[1] == 1'(gi / 2));
            assign lane_src = (funct3_reg[1:0] == 2'b00) ? wdata_reg[7:0]
                                                         : wdata_reg[8 * (gi % 2) +: 8];
            assign merge_word[8 * gi +: 8] = lane_hit ? lane_src : dmem_ReadData[8 * gi +: 8];
        end
    endgenerate

    // Request sequencing: accept, access the memory, then give one response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            funct3_reg <= 3'd0;
            addr_reg   <= 32'd0;
            wdata_reg  <= 16'd0;
            merge_reg  <= 32'd0;
            rdata_reg  <= 32'd0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_reg <= req_funct3;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata[15:0];
                        if (req_fault) begin
                            rdata_reg <= 32'd0;
                            err_reg   <= 1'b1;
                            state_reg <= S_RESP;
                        end else if (!req_we) begin
                            state_reg <= S_LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            merge_reg <= req_wdata;
                            state_reg <= S_WRITE;
                        end else begin
                            state_reg <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    rdata_reg <= ld_result;
                    err_reg   <= 1'b0;
                    state_reg <= S_RESP;
                end
                S_RMW_RD: begin
                    merge_reg <= merge_word;
                    state_reg <= S_WRITE;
                end
                S_WRITE: begin
                    rdata_reg <= 32'd0;
                    err_reg   <= 1'b0;
                    state_reg <= S_RESP;
                end
                S_RESP:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Strobes come from the state alone, so an asynchronous reset drops them at once.
    assign req_ready      = (state_reg == S_IDLE);
    assign resp_done      = (state_reg == S_RESP);
    assign dmem_MemRead   = (state_reg == S_LOAD) || (state_reg == S_RMW_RD);
    assign dmem_MemWrite  = (state_reg == S_WRITE);
    assign dmem_addr      = {addr_reg[31:2], 2'b00};
    assign dmem_WriteData = merge_reg;
    assign resp_rdata     = rdata_reg;
    assign resp_err       = err_reg;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw. A word-array memory model is attached to the
// DUT. A reference model predicts each transaction as it is accepted, and one
// monitor checks the outputs on every falling edge.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, resp_done, resp_err;
    logic [31:0] resp_rdata;
    logic        dmem_MemRead, dmem_MemWrite;
    logic [31:0] dmem_addr, dmem_WriteData, dmem_ReadData;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    int vectors = 0;
    int miscompares = 0;

    bit          mon_off = 1'b1;
    bit          pending = 1'b0;
    int          age, rd_cnt, wr_cnt;
    int          exp_lat, exp_rd, exp_wr;
    logic        exp_err;
    logic [31:0] exp_rdata, exp_waddr, exp_wdata, got_rdata;

    lsu_rmw #(.DMEM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_done(resp_done), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dmem_MemRead(dmem_MemRead), .dmem_MemWrite(dmem_MemWrite),
        .dmem_addr(dmem_addr), .dmem_WriteData(dmem_WriteData),
        .dmem_ReadData(dmem_ReadData)
    );

    always #5 clk = ~clk;

    // Word memory: it clears on reset, writes on the clock edge and reads combinationally.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (dmem_MemWrite) begin
            mem[dmem_addr[9:2]] <= dmem_WriteData;
        end
    end
    assign dmem_ReadData = dmem_MemRead ? mem[dmem_addr[9:2]] : 32'h0BAD0BAD;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, got, expv);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    endtask

    // Predict the result of one accepted request from the ISA rules and update the reference memory.
    task automatic predict(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w, b, h, mask, nw;
        int sh;
        bit bad;
        bad = we ? !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                 : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (f3[1:0] == 2'd1 && a[0]) bad = 1'b1;
        if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) bad = 1'b1;
        if (a[31:2] >= 30'd256) bad = 1'b1;
        exp_waddr = {a[31:2], 2'b00};
        exp_wdata = 32'd0;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        if (bad) begin
            exp_err = 1'b1; exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else begin
            w  = ref_mem[a[9:2]];
            b  = (w >> (8 * a[1:0])) & 32'hFF;
            h  = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
            if (!we) begin
                exp_lat = 2; exp_rd = 1; exp_wr = 0;
                case (f3)
                    3'd0:    exp_rdata = b | (b[7] ? 32'hFFFFFF00 : 32'd0);
                    3'd1:    exp_rdata = h | (h[15] ? 32'hFFFF0000 : 32'd0);
                    3'd4:    exp_rdata = b;
                    3'd5:    exp_rdata = h;
                    default: exp_rdata = w;
                endcase
            end else begin
                if (f3 == 3'd2) begin
                    nw = wd; exp_lat = 2; exp_rd = 0;
                end else if (f3 == 3'd0) begin
                    sh = 8 * a[1:0];
                    mask = 32'hFF << sh;
                    nw = (w & ~mask) | ((wd & 32'hFF) << sh);
                    exp_lat = 3; exp_rd = 1;
                end else begin
                    sh = a[1] ? 16 : 0;
                    mask = 32'hFFFF << sh;
                    nw = (w & ~mask) | ((wd & 32'hFFFF) << sh);
                    exp_lat = 3; exp_rd = 1;
                end
                exp_wr = 1;
                exp_wdata = nw;
                ref_mem[a[9:2]] = nw;
            end
        end
    endtask

    // One compare process: every falling edge, check the outputs against the prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_off && rst_n) begin
                if (pending) begin
                    age++;
                    check("busy_ready", {31'd0, req_ready}, 32'd0);
                    if (dmem_MemRead) begin
                        rd_cnt++;
                        check("rd_addr", dmem_addr, exp_waddr);
                    end
                    if (dmem_MemWrite) begin
                        wr_cnt++;
                        check("wr_addr", dmem_addr, exp_waddr);
                        check("wr_data", dmem_WriteData, exp_wdata);
                    end
                    if (resp_done) begin
                        check("latency", age, exp_lat);
                        check("rdata", resp_rdata, exp_rdata);
                        check("err", {31'd0, resp_err}, {31'd0, exp_err});
                        check("memread_cycles", rd_cnt, exp_rd);
                        check("memwrite_cycles", wr_cnt, exp_wr);
                        got_rdata = resp_rdata;
                        pending = 1'b0;
                    end else if (age > 6) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL timeout: no resp_done after %0d cycles, required %0d", age, exp_lat);
                        pending = 1'b0;
                    end
                end else begin
                    check("idle_done", {31'd0, resp_done}, 32'd0);
                    check("idle_ready", {31'd0, req_ready}, 32'd1);
                    check("idle_memrd", {31'd0, dmem_MemRead}, 32'd0);
                    check("idle_memwr", {31'd0, dmem_MemWrite}, 32'd0);
                end
            end
        end
    end

    // Issue one request, let the monitor check it, and optionally pin the load result to a literal.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit use_lit, input logic [31:0] lit,
                          input bit busy);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        predict(we, f3, a, wd);
        age = 0; rd_cnt = 0; wr_cnt = 0;
        pending = 1'b1;
        if (busy) begin
            req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        while (pending) @(posedge clk);
        #1;
        if (use_lit) check("literal", got_rdata, lit);
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_done"}, {31'd0, resp_done}, 32'd0);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        check({tag, "_err"}, {31'd0, resp_err}, 32'd0);
        check({tag, "_memrd"}, {31'd0, dmem_MemRead}, 32'd0);
        check({tag, "_memwr"}, {31'd0, dmem_MemWrite}, 32'd0);
        check({tag, "_addr"}, dmem_addr, 32'd0);
        check({tag, "_wdata"}, dmem_WriteData, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_ref();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        #2;
        reset_outputs("rst0");
        @(posedge clk); #1;
        reset_outputs("rst1");
        @(negedge clk);
        rst_n = 1'b1;
        mon_off = 1'b0;

        // Word store and load-back.
        do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'd0, 0);
        do_req(0, 3'b010, 32'h10, 32'd0, 1, 32'hDEADBEEF, 0);
        // Byte read-modify-write and byte loads.
        do_req(1, 3'b010, 32'h0C, 32'h11223344, 0, 32'd0, 0);
        do_req(1, 3'b000, 32'h0F, 32'h123456AA, 0, 32'd0, 0);
        do_req(0, 3'b010, 32'h0C, 32'd0, 1, 32'hAA223344, 0);
        do_req(0, 3'b000, 32'h0F, 32'd0, 1, 32'hFFFFFFAA, 0);
        do_req(0, 3'b100, 32'h0F, 32'd0, 1, 32'h000000AA, 0);
        do_req(0, 3'b000, 32'h0C, 32'd0, 1, 32'h00000044, 0);
        // Halfword read-modify-write and halfword loads.
        do_req(1, 3'b010, 32'h0C, 32'h11223344, 0, 32'd0, 0);
        do_req(1, 3'b001, 32'h0E, 32'h00008001, 0, 32'd0, 0);
        do_req(0, 3'b010, 32'h0C, 32'd0, 1, 32'h80013344, 0);
        do_req(0, 3'b001, 32'h0E, 32'd0, 1, 32'hFFFF8001, 0);
        do_req(0, 3'b101, 32'h0E, 32'd0, 1, 32'h00008001, 0);
        do_req(0, 3'b001, 32'h0C, 32'd0, 1, 32'h00003344, 0);
        // Faults: misaligned word, misaligned half, out of range, illegal funct3.
        do_req(0, 3'b010, 32'h06, 32'd0, 1, 32'd0, 0);
        do_req(1, 3'b001, 32'h05, 32'h5555, 0, 32'd0, 0);
        do_req(0, 3'b010, 32'h400, 32'd0, 1, 32'd0, 0);
        do_req(0, 3'b011, 32'h10, 32'd0, 1, 32'd0, 0);
        do_req(1, 3'b110, 32'h10, 32'd1, 0, 32'd0, 0);
        // Last word in range.
        do_req(1, 3'b000, 32'h3FD, 32'h000000C3, 0, 32'd0, 0);
        do_req(0, 3'b010, 32'h3FC, 32'd0, 1, 32'h0000C300, 0);
        // A new request during RMW_RD must be ignored.
        do_req(1, 3'b000, 32'h14, 32'h00000055, 0, 32'd0, 1);
        do_req(0, 3'b010, 32'h14, 32'd0, 1, 32'h00000055, 0);

        // Reset asserted during WRITE aborts the store with no response.
        mon_off = 1'b1;
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h77;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_rmw_rd", {31'd0, dmem_MemRead}, 32'd1);
        @(posedge clk); #1;
        check("abort_write", {31'd0, dmem_MemWrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_memwr_drop", {31'd0, dmem_MemWrite}, 32'd0);
        check("abort_memrd", {31'd0, dmem_MemRead}, 32'd0);
        check("abort_done", {31'd0, resp_done}, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        clear_ref();
        @(negedge clk);
        rst_n = 1'b1;
        mon_off = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_req(0, 3'b010, 32'h20, 32'd0, 1, 32'd0, 0);
        do_req(0, 3'b010, 32'h10, 32'd0, 1, 32'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
